// File: rtl/zhadan_pkg.sv
// rtl/zhadan_pkg.sv - shared state encodings and stage constants for the bomb game and its display
package zhadan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ARMED    = 2'b01,
        ST_DEFUSED  = 2'b10,
        ST_EXPLODED = 2'b11
    } zhadan_state_e;

    localparam int STAGES_DEF = 4;
    localparam int STAGE_W    = 3;

endpackage

// File: rtl/zhadan_kongzhi_if.sv
// rtl/zhadan_kongzhi_if.sv - player-input and display-facing signals of the bomb game controller
interface zhadan_kongzhi_if;
    import zhadan_pkg::*;

    logic               start;
    logic [3:0]         cut;
    logic [1:0]         code;
    logic [STAGE_W-1:0] fuse_stage;
    logic [1:0]         state;
    logic               tick;
    logic               blink;

    modport master (
        output start, cut, code,
        input  fuse_stage, state, tick, blink
    );

    modport slave (
        input  start, cut, code,
        output fuse_stage, state, tick, blink
    );
endinterface

// File: rtl/zhadan_tick_gen.sv
// rtl/zhadan_tick_gen.sv - free-running 0..TICK_DIV-1 prescaler with synchronous clear and wrap flag
module zhadan_tick_gen #(
    parameter int TICK_DIV = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic wrap_o
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // wrap_o marks the last count; the owner registers its effect at the same edge
    assign wrap_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || wrap_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/zhadan_kongzhi.sv
// rtl/zhadan_kongzhi.sv - bomb game controller: arms, burns the fuse per tick, resolves wire cuts
module zhadan_kongzhi
    import zhadan_pkg::*;
#(
    parameter int TICK_DIV = 5000,
    parameter int STAGES   = STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    zhadan_kongzhi_if.slave  bus
);
    localparam logic [STAGE_W-1:0] STAGES_V = STAGE_W'(STAGES);

    zhadan_state_e      state_q, state_d;
    logic [STAGE_W-1:0] fuse_q, fuse_d;
    logic               tick_q, tick_d;
    logic               blink_q, blink_d;
    logic [1:0]         code_q, code_d;
    logic [3:0]         cut_q;

    logic [3:0] cut_rise;
    logic [3:0] code_mask;
    logic       bad_rise, good_rise;
    logic       pre_clr, wrap;

    zhadan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (pre_clr),
        .wrap_o (wrap)
    );

    always_comb begin
        cut_rise          = bus.cut & ~cut_q;
        code_mask         = '0;
        code_mask[code_q] = 1'b1;
        bad_rise          = |(cut_rise & ~code_mask);
        good_rise         = |(cut_rise & code_mask);
    end

    always_comb begin
        state_d = state_q;
        fuse_d  = fuse_q;
        tick_d  = 1'b0;
        blink_d = blink_q;
        code_d  = code_q;
        pre_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // prescaler is held at 0 so arming always starts a full stage period
                pre_clr = 1'b1;
                blink_d = 1'b0;
                if (bus.start && (bus.cut == 4'b0000)) begin
                    state_d = ST_ARMED;
                    code_d  = bus.code;
                    fuse_d  = '0;
                end
            end
            ST_ARMED: begin
                // a wrong wire beats the right one, and the right one beats the final tick
                if (bad_rise) begin
                    state_d = ST_EXPLODED;
                    fuse_d  = STAGES_V;
                end else if (good_rise) begin
                    state_d = ST_DEFUSED;
                end else if (wrap) begin
                    tick_d = 1'b1;
                    fuse_d = fuse_q + 1'b1;
                    if (fuse_q == STAGES_V - 1'b1) begin
                        state_d = ST_EXPLODED;
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    state_d = ST_IDLE;
                    fuse_d  = '0;
                    blink_d = 1'b0;
                    pre_clr = 1'b1;
                end else if (wrap) begin
                    blink_d = ~blink_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            fuse_q  <= '0;
            tick_q  <= 1'b0;
            blink_q <= 1'b0;
            code_q  <= '0;
            cut_q   <= '0;
        end else begin
            state_q <= state_d;
            fuse_q  <= fuse_d;
            tick_q  <= tick_d;
            blink_q <= blink_d;
            code_q  <= code_d;
            cut_q   <= bus.cut;
        end
    end

    assign bus.state      = state_q;
    assign bus.fuse_stage = fuse_q;
    assign bus.tick       = tick_q;
    assign bus.blink      = blink_q;
endmodule

// File: tb/tb_zhadan_kongzhi.sv
// tb/tb_zhadan_kongzhi.sv - directed self-checking bench for the bomb game controller
module tb_zhadan_kongzhi;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    zhadan_kongzhi_if bus ();

    zhadan_kongzhi #(.TICK_DIV(8), .STAGES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [1:0] c);
        bus.code  = c;
        bus.cut   = 4'b0000;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("arm_state", bus.state, 2'b01);
        chk("arm_fuse", bus.fuse_stage, 0);
    endtask

    task automatic restart();
        bus.cut   = 4'b0000;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("restart_state", bus.state, 2'b00);
        chk("restart_fuse", bus.fuse_stage, 0);
        chk("restart_blink", bus.blink, 0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.cut   = 4'b0000;
        bus.code  = 2'b00;
        step(2);
        rst = 1'b0;
        chk("rst_state", bus.state, 0);
        chk("rst_fuse", bus.fuse_stage, 0);
        chk("rst_tick", bus.tick, 0);
        chk("rst_blink", bus.blink, 0);

        // timeout: ticks every 8 cycles, exploded at the 4th, then blink every 8
        arm(2'd2);
        for (int k = 1; k <= 32; k++) begin
            step(1);
            chk("to_tick", bus.tick, (k % 8 == 0) ? 1 : 0);
            chk("to_fuse", bus.fuse_stage, k / 8);
            chk("to_state", bus.state, (k == 32) ? 2'b11 : 2'b01);
        end
        for (int k = 33; k <= 48; k++) begin
            step(1);
            chk("to_blink", bus.blink, ((k - 32) / 8) % 2);
            chk("to_tick_post", bus.tick, 0);
            chk("to_fuse_sat", bus.fuse_stage, 4);
        end
        restart();

        // correct cut at cycle 12
        arm(2'd2);
        step(11);
        bus.cut = 4'b0100;
        step(1);
        chk("ok_state", bus.state, 2'b10);
        chk("ok_fuse", bus.fuse_stage, 1);
        for (int k = 0; k < 20; k++) begin
            step(1);
            chk("ok_tick", bus.tick, 0);
            chk("ok_fuse_frozen", bus.fuse_stage, 1);
            chk("ok_hold", bus.state, 2'b10);
        end
        restart();

        // wrong wire
        arm(2'd1);
        step(3);
        bus.cut = 4'b1000;
        step(1);
        chk("bad_state", bus.state, 2'b11);
        chk("bad_fuse", bus.fuse_stage, 4);
        restart();

        // start while armed is ignored, then right+wrong wire together explode
        arm(2'd1);
        step(2);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("armed_start_state", bus.state, 2'b01);
        chk("armed_start_fuse", bus.fuse_stage, 0);
        bus.cut = 4'b0011;
        step(1);
        chk("coin_state", bus.state, 2'b11);
        chk("coin_fuse", bus.fuse_stage, 4);
        restart();

        // correct cut in the cycle of the final wrap
        arm(2'd0);
        step(31);
        chk("race_pre_fuse", bus.fuse_stage, 3);
        bus.cut = 4'b0001;
        step(1);
        chk("race_state", bus.state, 2'b10);
        chk("race_fuse", bus.fuse_stage, 3);
        chk("race_tick", bus.tick, 0);
        restart();

        // arm guard with a wire already cut
        bus.cut   = 4'b0001;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("guard_state", bus.state, 2'b00);
        bus.cut = 4'b0000;
        step(1);

        // asynchronous reset mid-game
        arm(2'd3);
        step(17);
        chk("ar_pre_fuse", bus.fuse_stage, 2);
        chk("ar_pre_state", bus.state, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_state", bus.state, 0);
        chk("ar_fuse", bus.fuse_stage, 0);
        chk("ar_tick", bus.tick, 0);
        chk("ar_blink", bus.blink, 0);
        step(1);
        rst = 1'b0;
        step(1);
        arm(2'd3);
        step(7);
        chk("ar_new_tick0", bus.tick, 0);
        step(1);
        chk("ar_new_tick", bus.tick, 1);
        chk("ar_new_fuse", bus.fuse_stage, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/zhadan_kongzhi.md
Name: zhadan_kongzhi

Overview:
- Game controller for the bomb dot-matrix display. It sequences the fuse-burn stage (0..4) that the display block renders.
- Arms on a start pulse, then burns the fuse one stage per tick.
- Resolves wire-cut inputs into a defused or exploded outcome.
- Sits between the debounced player inputs and the dot-matrix display driver. It shares that driver's scan clock.

Parameters:
- TICK_DIV, 5000: clk cycles per fuse stage (1 s at 5 kHz scan clock); legal range 2..65535.
- STAGES, 4: fuse stages before explosion; fuse_stage saturates at STAGES.

Ports:
- clk  in  1  scan/system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse, already synchronised and debounced: arm from IDLE, or clear from a terminal state.
- cut  in  4  wire levels, already debounced; 1 = wire cut.
- code  in  2  index of the correct wire; sampled only when arming.
- fuse_stage  out  3  burnt stages 0..STAGES; drives the display's stage input.
- state  out  2  00 IDLE, 01 ARMED, 10 DEFUSED, 11 EXPLODED.
- tick  out  1  one-cycle pulse on each fuse advance while ARMED.
- blink  out  1  toggles every TICK_DIV cycles in DEFUSED/EXPLODED; 0 otherwise.

Behaviour:
- Reset values: state=IDLE, fuse_stage=0, tick=0, blink=0. Prescaler=0, code_q=0, cut_q=0. Reset mid-game aborts immediately, with no partial outcome.
- All outputs are registered. An input sampled at edge N takes effect in the outputs after edge N.
- cut_q registers cut every cycle. Edge vector cut_rise = cut & ~cut_q.
- IDLE:
  - start=1 and cut==0 → ARMED, code_q<=code, prescaler<=0, fuse_stage<=0.
  - start=1 and cut!=0 → ignored; stay IDLE.
- ARMED, prescaler and tick:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - At the wrap, tick=1 for one cycle and fuse_stage increments.
- ARMED, priority order (evaluated in the same cycle):
  1. Any cut_rise bit other than code_q → EXPLODED, fuse_stage<=STAGES. This holds even if the correct wire rises in the same cycle.
  2. cut_rise[code_q] alone → DEFUSED, fuse_stage frozen at its current value. This wins over a coincident final tick.
  3. Wrap with fuse_stage==STAGES-1 → fuse_stage<=STAGES, EXPLODED.
- ARMED, other rules:
  - start is ignored.
  - A falling edge on cut is ignored.
- DEFUSED / EXPLODED:
  - Prescaler keeps running; blink toggles at each wrap; tick=0.
  - cut changes are ignored.
  - start=1 → IDLE, fuse_stage<=0, blink<=0, prescaler<=0.
- Width rules:
  - Prescaler width is clog2(TICK_DIV).
  - fuse_stage never exceeds STAGES; there is no wrap to 0 except via IDLE.

Decomposition:
- Shared package zhadan_pkg: state encodings ST_IDLE/ST_ARMED/ST_DEFUSED/ST_EXPLODED, the STAGES default, and the stage width constant. The display driver uses the same package.
- One sub-module, zhadan_tick_gen: parameterised prescaler with synchronous clear input and one-cycle wrap pulse output.

Test Plan (bench sets TICK_DIV=8, STAGES=4):
- Timeout: rst, then start with code=2 and cut=0 → ticks at cycles 8/16/24/32 after arming; fuse_stage 1,2,3,4; state=11 at the 4th tick; blink toggles every 8 cycles.
- Correct cut: arm with code=2, raise cut[2] at cycle 12 → state=10 on the next edge; fuse_stage frozen at 1; no further tick pulses.
- Wrong cut and coincidence:
  - Arm with code=1, raise cut[3] → state=11, fuse_stage=4 immediately.
  - Separately, raise cut[1] and cut[0] in the same cycle → state=11.
- Final-tick race: arm with code=0, raise cut[0] in the cycle of the 4th wrap → state=10, fuse_stage=3.
- Arm guard and restart:
  - start while cut=0001 in IDLE → stays 00.
  - From EXPLODED, start → state=00, fuse_stage=0, blink=0.
  - start while ARMED → no change.
- Async reset: assert rst mid-ARMED, between clock edges, at fuse_stage=2 → all outputs 0 at once, before the next edge. After release, a start pulse arms a fresh game from stage 0.
